pipe_addsub: RTL
================

# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor; the wide-word successor of the team's 8-bit ripple adder. The WIDTH-bit operation is split into STAGES chunks of CHUNK bits. Each chunk ripples through full-adder cells, and the carry is registered between stages. The block sits in the datapath between an operand producer and a result consumer, with valid/ready on both sides. It sustains one operation per cycle, with full backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK (elaboration error otherwise)
- CHUNK, 8, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK (≥1)
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_ci  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result beat present
- out_ready  in  1  consumer takes the beat this cycle
- out_s  out  WIDTH  sum/difference
- out_co  out  1  carry out of bit WIDTH-1
- out_ovf  out  1  signed overflow

## Operation
- Accept on `in_valid & in_ready`. Deliver on `out_valid & out_ready`.
- Operand transform at entry:
  - b' = in_b XOR {WIDTH{in_sub}}
  - c0 = in_ci XOR in_sub
  - Add: s = a + b + ci.
  - Sub: s = a − b − ci, with ci as borrow-in.
- Stage k (0..STAGES-1) computes bits [k·CHUNK +: CHUNK] from the registered carry of stage k-1 (c0 for k=0).
  - Unresolved upper chunks of a and b' travel with the beat.
  - Resolved lower sum bits travel with the beat.
- out_co = carry out of the top chunk.
  - Add: carry.
  - Sub: out_co = 1 means no borrow.
- out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Each stage holds one valid bit plus data.
  - Stage k advances when its downstream stage is empty or advancing.
  - The last stage (output register) advances when out_ready = 1 or out_valid = 0.
- in_ready = stage 0 empty OR stage 0 advancing. This path is combinational from out_ready through the valid chain; no skid buffer.
- Output data is stable while `out_valid & ~out_ready` (hold rule). Beats are never dropped, duplicated or reordered.
- Operands and mode are sampled only on acceptance. Mode may change every beat.

## Timing
- Latency: a beat accepted at edge n is presented with out_valid = 1 after edge n+STAGES, provided no stall occurred.
- Throughput: 1 beat/cycle when out_ready is held high.
- Stall: with out_ready = 0 and all stages full, in_ready = 0. Once out_ready rises, in_ready rises in the same cycle.
- Bubbles collapse: an empty stage ahead of a stalled beat is filled even while out_ready = 0.
- Reset: while rst_n = 0 at an edge:
  - All valid bits clear.
  - out_valid = 0, out_s = 0, out_co = 0, out_ovf = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 in the first cycle after release.
- Reset mid-operation discards all in-flight beats. No partial results are emitted.
- STAGES = 1 degenerates to a single registered ripple adder with latency 1.

## Test plan
- Add, WIDTH=32/CHUNK=8: a = 0xFFFF_FFFF, b = 0x0000_0001, ci = 0, sub = 0 -> after 4 cycles: s = 0x0000_0000, co = 1, ovf = 0 (carry ripples across all stage boundaries).
- Subtract with overflow: a = 0x8000_0000, b = 0x0000_0001, sub = 1, ci = 0 -> s = 0x7FFF_FFFF, co = 1, ovf = 1. Same with ci = 1 -> s = 0x7FFF_FFFE.
- Streaming: 100 random back-to-back beats, mixed add/sub, out_ready = 1 -> one result per cycle after a 4-cycle fill, in order. Each result equals the reference model: (a ± b ± ci) mod 2^32, plus co and ovf.
- Backpressure:
  - Random out_ready at 50 %, random in_valid -> no loss or duplication.
  - out_s/out_co/out_ovf stay stable while stalled.
  - in_ready = 0 only when the pipeline is full and out_ready = 0.
- Reset mid-flight: 3 beats in the pipe, rst_n = 0 for 1 cycle -> out_valid = 0 and outputs zero next cycle. None of the 3 beats ever appears. A new beat (a = 5, b = 3, add) -> s = 8 after 4 cycles.
- Parameter sweep: WIDTH/CHUNK = 8/8, 16/4, 64/16 -> latency equals STAGES, and exhaustive (8/8) or random results match the model.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits resolved CHUNK bits per stage,
// carry registered between stages, valid/ready with full backpressure on both sides.
module pipe_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_co,
    output logic             out_ovf
);
    localparam int unsigned CHUNK_NZ = (CHUNK == 0) ? 1 : CHUNK;
    localparam int unsigned STAGES   = (WIDTH / CHUNK_NZ == 0) ? 1 : WIDTH / CHUNK_NZ;

    if (CHUNK == 0 || WIDTH < CHUNK || (WIDTH % CHUNK_NZ) != 0) begin : g_bad_param
        $error("pipe_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [STAGES-1:0] v_q, rdy, up_v;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;

    always_comb begin : comb_stages
        logic             r, c, c_top;
        logic [WIDTH-1:0] pa, pb, ps;
        int unsigned      j;
        int               pos;

        // A stage can load when it is empty or everything downstream can move.
        r = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            r      = r | ~v_q[k];
            rdy[k] = r;
        end
        in_ready = rdy[0] & rst_n;

        c_top = 1'b0;
        for (int k = 0; k < int'(STAGES); k++) begin
            j = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                pa      = in_a;
                pb      = in_b ^ {WIDTH{in_sub}};
                ps      = '0;
                c       = in_ci ^ in_sub;
                up_v[k] = in_valid & in_ready;
            end else begin
                pa      = a_q[j];
                pb      = b_q[j];
                ps      = s_q[j];
                c       = c_q[j];
                up_v[k] = v_q[j];
            end
            for (int i = 0; i < int'(CHUNK); i++) begin
                pos = k * int'(CHUNK) + i;
                if (pos == int'(WIDTH) - 1) c_top = c;
                ps[pos] = pa[pos] ^ pb[pos] ^ c;
                c       = (pa[pos] & pb[pos]) | (c & (pa[pos] ^ pb[pos]));
            end
            a_d[k] = pa;
            b_d[k] = pb;
            s_d[k] = ps;
            c_d[k] = c;
        end
        ovf_d = c_top ^ c_d[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (rdy[k]) begin
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        a_q[k] <= a_d[k];
                        b_q[k] <= b_d[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                    end
                end
            end
            if (rdy[STAGES-1] && up_v[STAGES-1]) ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_s     = s_q[STAGES-1];
    assign out_co    = c_q[STAGES-1];
    assign out_ovf   = ovf_q;

endmodule
